// File: rtl/pixel_reorder_stream.sv
// pixel_reorder_stream: collects out-of-order pixel results from several
// render engines into a small reorder window and emits them as a raster-order
// stream with first / end-of-line / last-line flags.
module pixel_reorder_stream #(
    parameter int NUM_ENGINES = 11,
    parameter int RGB_SIZE    = 24,
    parameter int COORD_WIDTH = 16,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int SLOTS       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_ENGINES-1:0]             eng_valid,
    input  logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_xpixel,
    input  logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_ypixel,
    input  logic [NUM_ENGINES*RGB_SIZE-1:0]    eng_colour,
    output logic [NUM_ENGINES-1:0]             eng_ready,
    input  logic                               ready,
    output logic [RGB_SIZE-1:0]                colour_o,
    output logic                               valid,
    output logic                               first,
    output logic                               last_x,
    output logic                               last_y,
    output logic                               frame_done,
    output logic                               err_sticky
);

    localparam int FRAME  = X_SIZE * Y_SIZE;
    localparam int IDX_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [IDX_W:0]         FRAME_EXT = (IDX_W+1)'(FRAME);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(FRAME - 1);
    localparam logic [COORD_WIDTH:0]   X_LIM     = (COORD_WIDTH+1)'(X_SIZE);
    localparam logic [COORD_WIDTH:0]   Y_LIM     = (COORD_WIDTH+1)'(Y_SIZE);
    localparam logic [COORD_WIDTH-1:0] X_MAX     = COORD_WIDTH'(X_SIZE - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX     = COORD_WIDTH'(Y_SIZE - 1);

    // Head of the raster: linear index plus its x/y so the flags need no divide.
    logic [IDX_W-1:0]       head_idx_reg;
    logic [COORD_WIDTH-1:0] head_x_reg;
    logic [COORD_WIDTH-1:0] head_y_reg;

    // Reorder buffer.
    logic [SLOTS-1:0]    occupied_reg;
    logic [SLOTS-1:0]    occupied_next;
    logic [RGB_SIZE-1:0] slot_colour_reg [SLOTS];

    // Output register.
    logic                valid_reg;
    logic [RGB_SIZE-1:0] colour_reg;
    logic                first_reg;
    logic                last_x_reg;
    logic                last_y_reg;
    logic                frame_done_reg;
    logic                err_sticky_reg;

    // Per-engine decode.
    logic [NUM_ENGINES-1:0][IDX_W-1:0]    eng_idx;
    logic [NUM_ENGINES-1:0][RGB_SIZE-1:0] eng_col;
    logic [NUM_ENGINES-1:0]               eng_oof;
    logic [NUM_ENGINES-1:0]               eng_cand;
    logic [NUM_ENGINES-1:0]               grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
            logic [COORD_WIDTH-1:0] x_w;
            logic [COORD_WIDTH-1:0] y_w;
            logic [IDX_W:0]         off_w;

            assign x_w         = eng_xpixel[gi*COORD_WIDTH +: COORD_WIDTH];
            assign y_w         = eng_ypixel[gi*COORD_WIDTH +: COORD_WIDTH];
            assign eng_col[gi] = eng_colour[gi*RGB_SIZE +: RGB_SIZE];
            assign eng_oof[gi] = ({1'b0, x_w} >= X_LIM) || ({1'b0, y_w} >= Y_LIM);
            assign eng_idx[gi] = IDX_W'(y_w) * IDX_W'(X_SIZE) + IDX_W'(x_w);
            // Distance ahead of the head, modulo the frame size.
            assign off_w = (eng_idx[gi] >= head_idx_reg)
                         ? {1'b0, eng_idx[gi]} - {1'b0, head_idx_reg}
                         : {1'b0, eng_idx[gi]} + FRAME_EXT - {1'b0, head_idx_reg};
            // Out-of-frame results are always taken (and dropped) so they cannot block.
            assign eng_cand[gi] = eng_valid[gi] && (eng_oof[gi] || (32'(off_w) < SLOTS));
        end
    endgenerate

    // Lowest-numbered eligible engine wins.
    assign grant     = eng_cand & ~(eng_cand - NUM_ENGINES'(1));
    assign eng_ready = reset ? grant : '0;

    logic [IDX_W-1:0]    sel_idx;
    logic [RGB_SIZE-1:0] sel_col;
    logic                sel_oof;
    logic                acc_write;
    logic [SLOT_W-1:0]   acc_slot;
    logic [SLOT_W-1:0]   head_slot;
    logic                bypass;
    logic                load;
    logic [RGB_SIZE-1:0] load_colour;
    logic                overwrite_err;

    // Mux the granted engine's result.
    always_comb begin
        sel_idx = '0;
        sel_col = '0;
        sel_oof = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (grant[i]) begin
                sel_idx = eng_idx[i];
                sel_col = eng_col[i];
                sel_oof = eng_oof[i];
            end
        end
    end

    assign acc_write     = (|grant) && !sel_oof;
    assign acc_slot      = SLOT_W'(sel_idx);
    assign head_slot     = SLOT_W'(head_idx_reg);
    assign bypass        = acc_write && (acc_slot == head_slot);
    assign load          = (!valid_reg || ready) && (occupied_reg[head_slot] || bypass);
    assign load_colour   = bypass ? sel_col : slot_colour_reg[head_slot];
    assign overwrite_err = acc_write && occupied_reg[acc_slot];

    // Occupancy update: the head slot empties on load; a bypassed write never lands.
    always_comb begin
        occupied_next = occupied_reg;
        if (load) begin
            occupied_next[head_slot] = 1'b0;
        end
        if (acc_write && !(load && bypass)) begin
            occupied_next[acc_slot] = 1'b1;
        end
    end

    // Slot colour storage; validity lives in occupied_reg so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc_write) begin
            slot_colour_reg[acc_slot] <= sel_col;
        end
    end

    // Head pointer, occupancy, output register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_idx_reg   <= '0;
            head_x_reg     <= '0;
            head_y_reg     <= '0;
            occupied_reg   <= '0;
            valid_reg      <= 1'b0;
            colour_reg     <= '0;
            first_reg      <= 1'b0;
            last_x_reg     <= 1'b0;
            last_y_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            occupied_reg   <= occupied_next;
            frame_done_reg <= valid_reg && ready && last_x_reg && last_y_reg;
            if ((|grant && sel_oof) || overwrite_err) begin
                err_sticky_reg <= 1'b1;
            end
            if (load) begin
                valid_reg    <= 1'b1;
                colour_reg   <= load_colour;
                first_reg    <= (head_idx_reg == '0);
                last_x_reg   <= (head_x_reg == X_MAX);
                last_y_reg   <= (head_y_reg == Y_MAX);
                head_idx_reg <= (head_idx_reg == LAST_IDX) ? '0 : head_idx_reg + IDX_W'(1);
                if (head_x_reg == X_MAX) begin
                    head_x_reg <= '0;
                    head_y_reg <= (head_y_reg == Y_MAX) ? '0 : head_y_reg + COORD_WIDTH'(1);
                end else begin
                    head_x_reg <= head_x_reg + COORD_WIDTH'(1);
                end
            end else if (ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign colour_o   = colour_reg;
    assign valid      = valid_reg;
    assign first      = first_reg;
    assign last_x     = last_x_reg;
    assign last_y     = last_y_reg;
    assign frame_done = frame_done_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_pixel_reorder_stream.sv
// Testbench for pixel_reorder_stream: engines are fed from per-engine job
// queues; a frame-level model (pending pixels keyed by linear index) predicts
// grants, the output stream and the status flags every cycle.
module tb_pixel_reorder_stream;

    localparam int NE    = 4;
    localparam int RGB   = 24;
    localparam int CW    = 16;
    localparam int XS    = 8;
    localparam int YS    = 4;
    localparam int SL    = 16;
    localparam int FRAME = XS * YS;

    logic              clk = 1'b0;
    logic              reset;
    logic [NE-1:0]     eng_valid;
    logic [NE*CW-1:0]  eng_xpixel;
    logic [NE*CW-1:0]  eng_ypixel;
    logic [NE*RGB-1:0] eng_colour;
    logic [NE-1:0]     eng_ready;
    logic              ds_ready;
    logic [RGB-1:0]    colour_o;
    logic              valid, first, last_x, last_y, frame_done, err_sticky;

    pixel_reorder_stream #(
        .NUM_ENGINES(NE), .RGB_SIZE(RGB), .COORD_WIDTH(CW),
        .X_SIZE(XS), .Y_SIZE(YS), .SLOTS(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .eng_valid(eng_valid), .eng_xpixel(eng_xpixel), .eng_ypixel(eng_ypixel),
        .eng_colour(eng_colour), .eng_ready(eng_ready), .ready(ds_ready),
        .colour_o(colour_o), .valid(valid), .first(first), .last_x(last_x),
        .last_y(last_y), .frame_done(frame_done), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]  x;
        logic [CW-1:0]  y;
        logic [RGB-1:0] c;
    } res_t;

    res_t eq [NE][$];

    // Frame-level reference state.
    logic [RGB-1:0] pend [int];
    bit             m_valid, m_first, m_lx, m_ly, m_done, m_err;
    logic [RGB-1:0] m_colour;
    int             m_head, m_out_idx;
    bit             rand_ready;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit acceptable(input res_t r);
        int idx, off;
        if (int'(r.x) >= XS || int'(r.y) >= YS) return 1'b1;
        idx = int'(r.y) * XS + int'(r.x);
        off = (idx - m_head + FRAME) % FRAME;
        return off < SL;
    endfunction

    task automatic push(input int e, input int x, input int y, input logic [RGB-1:0] c);
        res_t r;
        r.x = CW'(x);
        r.y = CW'(y);
        r.c = c;
        eq[e].push_back(r);
    endtask

    task automatic model_reset();
        pend.delete();
        m_valid = 0; m_first = 0; m_lx = 0; m_ly = 0; m_done = 0; m_err = 0;
        m_colour = '0; m_head = 0; m_out_idx = 0;
    endtask

    // One clock cycle: present queue heads, check grant, advance model, check outputs.
    task automatic step();
        int sel, idx;
        logic [NE-1:0] exp_rdy;
        res_t r;
        bit xfer, nd;
        if (rand_ready) ds_ready = ($urandom_range(0, 3) != 0);
        for (int e = 0; e < NE; e++) begin
            if (eq[e].size() > 0) begin
                eng_valid[e] = 1'b1;
                eng_xpixel[e*CW +: CW]   = eq[e][0].x;
                eng_ypixel[e*CW +: CW]   = eq[e][0].y;
                eng_colour[e*RGB +: RGB] = eq[e][0].c;
            end else begin
                eng_valid[e] = 1'b0;
            end
        end
        #1;
        sel = -1;
        for (int e = NE - 1; e >= 0; e--)
            if (eq[e].size() > 0 && acceptable(eq[e][0])) sel = e;
        exp_rdy = '0;
        if (sel >= 0) exp_rdy[sel] = 1'b1;
        check_value("eng_ready", 64'(eng_ready), 64'(exp_rdy));
        @(posedge clk);
        xfer = m_valid && ds_ready;
        if (xfer)
            $display("XFER idx=%0d colour=%06h first=%0b last_x=%0b last_y=%0b",
                     m_out_idx, m_colour, m_first, m_lx, m_ly);
        nd = xfer && m_lx && m_ly;
        if (sel >= 0) begin
            r = eq[sel].pop_front();
            if (int'(r.x) >= XS || int'(r.y) >= YS) begin
                m_err = 1;
            end else begin
                idx = int'(r.y) * XS + int'(r.x);
                if (pend.exists(idx)) m_err = 1;
                pend[idx] = r.c;
            end
        end
        if ((!m_valid || ds_ready) && pend.exists(m_head)) begin
            m_colour  = pend[m_head];
            pend.delete(m_head);
            m_valid   = 1;
            m_first   = (m_head == 0);
            m_lx      = ((m_head % XS) == XS - 1);
            m_ly      = ((m_head / XS) == YS - 1);
            m_out_idx = m_head;
            m_head    = (m_head + 1) % FRAME;
        end else if (ds_ready) begin
            m_valid = 0;
        end
        m_done = nd;
        #1;
        check_value("valid", 64'(valid), 64'(m_valid));
        check_value("frame_done", 64'(frame_done), 64'(m_done));
        check_value("err_sticky", 64'(err_sticky), 64'(m_err));
        if (m_valid) begin
            check_value("colour_o", 64'(colour_o), 64'(m_colour));
            check_value("first", 64'(first), 64'(m_first));
            check_value("last_x", 64'(last_x), 64'(m_lx));
            check_value("last_y", 64'(last_y), 64'(m_ly));
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic bit all_idle();
        for (int e = 0; e < NE; e++) if (eq[e].size() != 0) return 1'b0;
        return (pend.size() == 0) && !m_valid;
    endfunction

    task automatic drain(input int limit);
        int n = 0;
        while (!all_idle() && n < limit) begin
            step();
            n++;
        end
        if (!all_idle()) check_value("drain_timeout", 64'(pend.size() + 1), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check_value("rst_valid", 64'(valid), 64'(0));
        check_value("rst_colour_o", 64'(colour_o), 64'(0));
        check_value("rst_first", 64'(first), 64'(0));
        check_value("rst_last_x", 64'(last_x), 64'(0));
        check_value("rst_last_y", 64'(last_y), 64'(0));
        check_value("rst_frame_done", 64'(frame_done), 64'(0));
        check_value("rst_err_sticky", 64'(err_sticky), 64'(0));
        check_value("rst_eng_ready", 64'(eng_ready), 64'(0));
    endtask

    initial begin
        int idxs [4];
        int base, tmp, j, idx;

        reset      = 1'b0;
        ds_ready   = 1'b1;
        rand_ready = 0;
        eng_valid  = '1;
        eng_xpixel = '0;
        eng_ypixel = '0;
        eng_colour = '1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        // In-order raster from engine 0.
        for (int i = 0; i < 4; i++) push(0, i, 0, RGB'($urandom));
        drain(50);

        // Out-of-order in the same cycle: engines 2,1,0 hold indices 6,5,4.
        push(2, 6, 0, RGB'($urandom));
        push(1, 5, 0, RGB'($urandom));
        push(0, 4, 0, RGB'($urandom));
        drain(50);

        // Window stall: head is 7, index 23 sits just outside the window.
        push(3, 7, 2, RGB'($urandom));
        run(3);
        push(0, 7, 0, RGB'($urandom));
        run(2);
        for (int i = 8; i < 23; i++) push(1 + (i % 2), i % XS, i / XS, RGB'($urandom));
        run(3);
        // Backpressure with a pixel held on the output.
        ds_ready = 1'b0;
        run(5);
        ds_ready = 1'b1;
        drain(100);

        // Duplicate index overwrites a buffered slot.
        push(0, 1, 3, RGB'($urandom));
        push(1, 1, 3, RGB'($urandom));
        run(3);
        push(2, 0, 3, RGB'($urandom));
        drain(50);

        // Mid-frame reset with a pixel buffered behind a gap.
        push(0, 3, 3, RGB'($urandom));
        run(2);
        reset     = 1'b0;
        eng_valid = '1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        for (int e = 0; e < NE; e++) eq[e].delete();
        model_reset();
        reset = 1'b1;

        // Restart at pixel 0 alongside out-of-frame results.
        push(0, 0, 0, RGB'($urandom));
        push(1, 640, 0, RGB'($urandom));
        push(2, 2, 7, RGB'($urandom));
        drain(50);

        // Randomised: two frames, locally shuffled, spread over random engines.
        base = m_head;
        for (int b = 0; b < (2 * FRAME) / 4; b++) begin
            for (int k = 0; k < 4; k++) idxs[k] = (base + b * 4 + k) % FRAME;
            for (int k = 3; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = idxs[k]; idxs[k] = idxs[j]; idxs[j] = tmp;
            end
            for (int k = 0; k < 4; k++) begin
                idx = idxs[k];
                if ($urandom_range(0, 15) == 0)
                    push($urandom_range(0, NE - 1), XS + $urandom_range(0, 9), 0, RGB'($urandom));
                push($urandom_range(0, NE - 1), idx % XS, idx / XS, RGB'($urandom));
            end
        end
        rand_ready = 1;
        drain(3000);
        rand_ready = 0;
        ds_ready   = 1'b1;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
